if_fetch_unit: RTL and testbench

Instruction-fetch front end of the 5-stage core: owns the fetch PC, issues requests on the instruction-memory req/ack port, and presents a registered `{inst, pc, valid}` triple to the IF-stage instruction mux and the IF/ID register. It handles trap, mret and branch/jump redirects, including redirects that arrive while a memory request is outstanding. A one-entry skid buffer absorbs a response that lands while downstream is stalled.

---
 rtl/if_fetch_unit.sv | 222 ++++++++++++++++++++++
 tb/tb_if_fetch_unit.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit
// Instruction-fetch front end: owns the fetch PC, drives the instruction
// memory req/ack port and presents a registered {inst, pc, valid} triple
// to the IF stage. Handles trap / mret / branch-jump redirects, including
// redirects that land while a request is still in flight (DRAIN), and a
// one-entry skid buffer for a response that arrives while downstream stalls.

module if_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifetch_stall,
   input  logic        ifetch_redirect_trap,
   input  logic [31:0] ifetch_mtvec,
   input  logic        ifetch_redirect_mret,
   input  logic [31:0] ifetch_mepc,
   input  logic        ifetch_redirect_bj,
   input  logic [31:0] ifetch_bj_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] ifetch_inst,
   output logic [31:0] ifetch_pc,
   output logic        ifetch_valid
);

   // FETCH: request active for pc_q.
   // DRAIN: a request is outstanding but its response is already stale.
   // SKID : skid buffer holds a response, no request issued.
   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_DRAIN = 2'd1,
      ST_SKID  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pend_q, pend_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic [31:0] skid_pc_q, skid_pc_d;
   logic [31:0] out_inst_q, out_inst_d;
   logic [31:0] out_pc_q, out_pc_d;
   logic        out_valid_q, out_valid_d;

   logic        redirect_s;
   logic [31:0] redirect_target_s;
   logic        slot_free_s;
   logic [31:0] pc_plus4_s;
   logic [31:0] out_data_s;

   // Combine the three redirect sources; trap outranks mret, mret outranks bj.
   always_comb begin
      redirect_s = ifetch_redirect_trap | ifetch_redirect_mret | ifetch_redirect_bj;
      if (ifetch_redirect_trap) begin
         redirect_target_s = ifetch_mtvec;
      end else if (ifetch_redirect_mret) begin
         redirect_target_s = ifetch_mepc;
      end else begin
         redirect_target_s = ifetch_bj_target;
      end
   end

   // The output slot can take new data when it is empty or being consumed.
   always_comb begin
      slot_free_s = !out_valid_q || !ifetch_stall;
      pc_plus4_s  = pc_q + 32'd4;
   end

   // State register of the fetch FSM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decision of the fetch FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect_s) begin
                  state_d = ST_FETCH;
               end else if (slot_free_s) begin
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_SKID;
               end
            end else if (redirect_s) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DRAIN: begin
            if (imem_ack) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         ST_SKID: begin
            if (redirect_s) begin
               state_d = ST_FETCH;
            end else if (!ifetch_stall) begin
               state_d = ST_FETCH;
            end else begin
               state_d = ST_SKID;
            end
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   // Datapath updates (PC, pending target, skid entry, output triple) per state.
   always_comb begin
      pc_d        = pc_q;
      pend_d      = pend_q;
      skid_inst_d = skid_inst_q;
      skid_pc_d   = skid_pc_q;
      out_data_s  = out_inst_q;
      out_pc_d    = out_pc_q;
      // A consumed or empty slot falls back to invalid unless reloaded below.
      out_valid_d = slot_free_s ? 1'b0 : out_valid_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               if (redirect_s) begin
                  // Response belongs to the old path: drop it and restart.
                  pc_d        = redirect_target_s;
                  out_valid_d = 1'b0;
               end else if (slot_free_s) begin
                  out_data_s  = imem_rdata;
                  out_pc_d    = pc_q;
                  out_valid_d = 1'b1;
                  pc_d        = pc_plus4_s;
               end else begin
                  skid_inst_d = imem_rdata;
                  skid_pc_d   = pc_q;
                  pc_d        = pc_plus4_s;
               end
            end else if (redirect_s) begin
               // Request still in flight: remember where to go once it drains.
               pend_d      = redirect_target_s;
               out_valid_d = 1'b0;
            end else begin
               pend_d = pend_q;
            end
         end
         ST_DRAIN: begin
            out_valid_d = 1'b0;
            if (imem_ack) begin
               if (redirect_s) begin
                  pc_d = redirect_target_s;
               end else begin
                  pc_d = pend_q;
               end
            end else if (redirect_s) begin
               // Latest redirect wins.
               pend_d = redirect_target_s;
            end else begin
               pend_d = pend_q;
            end
         end
         ST_SKID: begin
            if (redirect_s) begin
               pc_d        = redirect_target_s;
               out_valid_d = 1'b0;
            end else if (!ifetch_stall) begin
               out_data_s  = skid_inst_q;
               out_pc_d    = skid_pc_q;
               out_valid_d = 1'b1;
            end else begin
               out_valid_d = out_valid_q;
            end
         end
         default: begin
            out_valid_d = 1'b0;
         end
      endcase
      // An invalid slot always carries the NOP encoding.
      out_inst_d = out_valid_d ? out_data_s : NOP_INST;
   end

   // Datapath registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q        <= RESET_PC;
         pend_q      <= 32'h0000_0000;
         skid_inst_q <= 32'h0000_0000;
         skid_pc_q   <= 32'h0000_0000;
         out_inst_q  <= NOP_INST;
         out_pc_q    <= RESET_PC;
         out_valid_q <= 1'b0;
      end else begin
         pc_q        <= pc_d;
         pend_q      <= pend_d;
         skid_inst_q <= skid_inst_d;
         skid_pc_q   <= skid_pc_d;
         out_inst_q  <= out_inst_d;
         out_pc_q    <= out_pc_d;
         out_valid_q <= out_valid_d;
      end
   end

   // Output decode: request is live in FETCH/DRAIN and forced low during reset.
   always_comb begin
      imem_req     = ((state_q == ST_FETCH) || (state_q == ST_DRAIN)) && !rst;
      imem_addr    = pc_q;
      ifetch_inst  = out_inst_q;
      ifetch_pc    = out_pc_q;
      ifetch_valid = out_valid_q;
   end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios followed by a
// randomized phase checked against a stream-level reference model (expected
// next delivered PC, memory contents as a pure function of the address).

module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        ifetch_stall;
   logic        ifetch_redirect_trap;
   logic [31:0] ifetch_mtvec;
   logic        ifetch_redirect_mret;
   logic [31:0] ifetch_mepc;
   logic        ifetch_redirect_bj;
   logic [31:0] ifetch_bj_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] ifetch_inst;
   logic [31:0] ifetch_pc;
   logic        ifetch_valid;

   int n_vec = 0;
   int n_err = 0;

   // model state for the random phase
   logic [31:0] exp_pc;
   logic [31:0] hold_addr;
   logic        flush_pend;
   logic        hold_pend;
   int          n_consumed;

   if_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .ifetch_stall         (ifetch_stall),
      .ifetch_redirect_trap (ifetch_redirect_trap),
      .ifetch_mtvec         (ifetch_mtvec),
      .ifetch_redirect_mret (ifetch_redirect_mret),
      .ifetch_mepc          (ifetch_mepc),
      .ifetch_redirect_bj   (ifetch_redirect_bj),
      .ifetch_bj_target     (ifetch_bj_target),
      .imem_req             (imem_req),
      .imem_addr            (imem_addr),
      .imem_ack             (imem_ack),
      .imem_rdata           (imem_rdata),
      .ifetch_inst          (ifetch_inst),
      .ifetch_pc            (ifetch_pc),
      .ifetch_valid         (ifetch_valid)
   );

   always #5 clk = ~clk;

   // memory contents: a fixed scramble of the address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
   endfunction

   function automatic logic [31:0] rand_target();
      logic [31:0] t;
      if ($urandom_range(0, 3) == 0) t = 32'hFFFF_FFFC;
      else t = $urandom;
      return t;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec = n_vec + 1;
      assert (obs === exp)
      else begin
         n_err = n_err + 1;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic ack, input logic stall,
                        input logic trap, input logic [31:0] tv,
                        input logic mret, input logic [31:0] mv,
                        input logic bj, input logic [31:0] bv);
      imem_ack             = ack;
      imem_rdata           = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      ifetch_stall         = stall;
      ifetch_redirect_trap = trap;
      ifetch_mtvec         = tv;
      ifetch_redirect_mret = mret;
      ifetch_mepc          = mv;
      ifetch_redirect_bj   = bj;
      ifetch_bj_target     = bv;
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
      chk({tag, "_valid"}, {31'd0, ifetch_valid}, {31'd0, v});
      if (v) begin
         chk({tag, "_pc"}, ifetch_pc, pc);
         chk({tag, "_inst"}, ifetch_inst, mem_word(pc));
      end else begin
         chk({tag, "_nop"}, ifetch_inst, NOP);
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      @(negedge clk);
      // reset values
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, RST_PC);
      chk("rst_valid", {31'd0, ifetch_valid}, 32'd0);
      chk("rst_inst", ifetch_inst, NOP);
      chk("rst_pc", ifetch_pc, RST_PC);
      rst = 1'b0;
      #1;
      chk("first_req", {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // streaming, ack every cycle
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk("strm_addr1", imem_addr, 32'h4);
      chk_out("strm1", 1'b1, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk("strm_addr2", imem_addr, 32'h8);
      chk_out("strm2", 1'b1, 32'h4);
      // redirect in the same cycle as the ack for 0x8
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h100);
      tick();
      chk_out("rdack", 1'b0, 32'h0);
      chk("rdack_addr", imem_addr, 32'h100);
      chk("rdack_req", {31'd0, imem_req}, 32'd1);

      // stall with skid
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk_out("skid0", 1'b1, 32'h100);
      drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 2; i++) begin
         chk("skid_req", {31'd0, imem_req}, 32'd0);
         chk_out("skid_hold", 1'b1, 32'h100);
         drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
         tick();
      end
      chk_out("skid_hold3", 1'b1, 32'h100);
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk_out("skid_out", 1'b1, 32'h104);
      chk("skid_addr", imem_addr, 32'h108);
      chk("skid_req2", {31'd0, imem_req}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk_out("skid_next", 1'b1, 32'h108);

      // redirect while waiting: move to 0x10, then hold the request there
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h10);
      tick();
      chk("drn_addr0", imem_addr, 32'h10);
      drive(1'b0, 1'b0, 1'b1, 32'h200, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      for (int i = 0; i < 7; i++) begin
         chk("drn_addr", imem_addr, 32'h10);
         chk("drn_req", {31'd0, imem_req}, 32'd1);
         chk_out("drn", 1'b0, 32'h0);
         if (i == 1) drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'h300);
         else if (i == 6) drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
         else drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
         tick();
      end
      chk("drn_target", imem_addr, 32'h300);
      chk_out("drn_after", 1'b0, 32'h0);

      // priority
      drive(1'b1, 1'b0, 1'b1, 32'h200, 1'b1, 32'h80, 1'b1, 32'h300);
      tick();
      chk("prio_trap", imem_addr, 32'h200);
      drive(1'b1, 1'b0, 1'b0, 32'h200, 1'b1, 32'h80, 1'b1, 32'h300);
      tick();
      chk("prio_mret", imem_addr, 32'h80);

      // wrap
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
      tick();
      chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      chk("wrap_addr1", imem_addr, 32'h0);
      chk_out("wrap", 1'b1, 32'hFFFF_FFFC);

      // reset mid-stream, then randomized traffic against the stream model
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
      #1;
      chk("rst2_req", {31'd0, imem_req}, 32'd0);
      chk("rst2_valid", {31'd0, ifetch_valid}, 32'd0);
      chk("rst2_addr", imem_addr, RST_PC);
      @(negedge clk);
      rst = 1'b0;
      exp_pc     = RST_PC;
      flush_pend = 1'b0;
      hold_pend  = 1'b0;
      n_consumed = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (flush_pend) chk("r_flush", {31'd0, ifetch_valid}, 32'd0);
         if (hold_pend) begin
            chk("r_addr_stable", imem_addr, hold_addr);
            chk("r_req_held", {31'd0, imem_req}, 32'd1);
         end
         if (!ifetch_valid) chk("r_nop", ifetch_inst, NOP);
         ifetch_stall         = ($urandom_range(0, 2) == 0);
         imem_ack             = imem_req && ($urandom_range(0, 3) != 0);
         imem_rdata           = imem_ack ? mem_word(imem_addr) : $urandom;
         ifetch_redirect_trap = ($urandom_range(0, 19) == 0);
         ifetch_redirect_mret = ($urandom_range(0, 19) == 0);
         ifetch_redirect_bj   = ($urandom_range(0, 11) == 0);
         ifetch_mtvec         = rand_target();
         ifetch_mepc          = rand_target();
         ifetch_bj_target     = rand_target();
         // instruction consumed this cycle must be the next one on the path
         if (ifetch_valid && !ifetch_stall) begin
            chk("r_pc", ifetch_pc, exp_pc);
            chk("r_inst", ifetch_inst, mem_word(exp_pc));
            exp_pc     = exp_pc + 32'd4;
            n_consumed = n_consumed + 1;
         end
         if (ifetch_redirect_trap) exp_pc = ifetch_mtvec;
         else if (ifetch_redirect_mret) exp_pc = ifetch_mepc;
         else if (ifetch_redirect_bj) exp_pc = ifetch_bj_target;
         flush_pend = ifetch_redirect_trap | ifetch_redirect_mret | ifetch_redirect_bj;
         hold_pend  = imem_req && !imem_ack;
         hold_addr  = imem_addr;
         tick();
      end
      chk("r_progress", {31'd0, (n_consumed >= 100)}, 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
